// File: rtl/stream_record_packer_if.sv
// AXI-Stream byte-lane bus between the record packer and the DMA write path.
interface stream_record_packer_if #(
    parameter int unsigned DATA_BUS_WIDTH_BYTES = 8
);
    logic [DATA_BUS_WIDTH_BYTES*8-1:0] tdata;
    logic [DATA_BUS_WIDTH_BYTES-1:0]   tkeep;
    logic                              tlast;
    logic                              tvalid;
    logic                              tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/stream_record_packer.sv
// Drains completed records from the element array in strict ring order and
// repacks them back-to-back into full-width stream beats; flush emits the residue.
module stream_record_packer #(
    parameter int unsigned DATA_BUS_WIDTH_BYTES = 8,
    parameter int unsigned MAX_RECORD_BYTES     = 34,
    parameter int unsigned NUM_SOURCES          = 4,
    localparam int unsigned LW = $clog2(MAX_RECORD_BYTES + 1)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_SOURCES-1:0][MAX_RECORD_BYTES-1:0][7:0] recData,
    input  logic [NUM_SOURCES-1:0][LW-1:0]                recLength,
    output logic [NUM_SOURCES-1:0]                        recTaken,
    input  logic                                          flushIn,
    output logic                                          errLength,
    stream_record_packer_if.master                        m
);
    localparam int unsigned W  = DATA_BUS_WIDTH_BYTES;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned AW = LW + 1;
    localparam int unsigned SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int unsigned RB = MAX_RECORD_BYTES * 8;
    localparam int unsigned BB = W * 8;

    typedef enum logic [1:0] {IDLE, EMIT, FLUSH} state_t;

    state_t        state;
    logic [SW-1:0] src_sel;
    logic [RB-1:0] rec_buf;
    logic [LW-1:0] rec_rem;
    logic [BB-1:0] res_buf;
    logic [CW-1:0] res_cnt;
    logic          flush_pending;

    logic          out_free_c;
    logic [AW-1:0] avail_c;
    logic [AW-1:0] take_n_c;
    logic [BB-1:0] merged_c;
    logic [BB-1:0] lane_mask_c;
    logic [W-1:0]  flush_keep_c;
    logic [LW-1:0] sel_len_c;
    logic          clipped_c;

    // Residue lanes stay zero above res_cnt, so OR-ing the shifted record in merges them.
    always_comb begin
        out_free_c   = !m.tvalid || m.tready;
        avail_c      = AW'(rec_rem) + AW'(res_cnt);
        take_n_c     = AW'(W) - AW'(res_cnt);
        merged_c     = res_buf | (BB'(rec_buf) << {res_cnt, 3'b000});
        lane_mask_c  = '0;
        flush_keep_c = '0;
        for (int unsigned k = 0; k < W; k++) begin
            if (AW'(k) < avail_c) lane_mask_c[8*k +: 8] = 8'hFF;
            if (CW'(k) < res_cnt) flush_keep_c[k] = 1'b1;
        end
        sel_len_c = recLength[src_sel];
        clipped_c = sel_len_c > LW'(MAX_RECORD_BYTES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            src_sel       <= '0;
            rec_buf       <= '0;
            rec_rem       <= '0;
            res_buf       <= '0;
            res_cnt       <= '0;
            flush_pending <= 1'b0;
            recTaken      <= '0;
            errLength     <= 1'b0;
            m.tdata       <= '0;
            m.tkeep       <= '0;
            m.tlast       <= 1'b0;
            m.tvalid      <= 1'b0;
        end else begin
            recTaken      <= '0;
            flush_pending <= flush_pending | flushIn;
            if (m.tvalid && m.tready) m.tvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (flush_pending) begin
                        if (res_cnt != '0) state <= FLUSH;
                        else flush_pending <= flushIn;
                    end else if (sel_len_c != '0 && !recTaken[src_sel]) begin
                        rec_buf           <= recData[src_sel];
                        rec_rem           <= clipped_c ? LW'(MAX_RECORD_BYTES) : sel_len_c;
                        if (clipped_c) errLength <= 1'b1;
                        recTaken[src_sel] <= 1'b1;
                        src_sel           <= (src_sel == SW'(NUM_SOURCES - 1)) ? '0 : src_sel + SW'(1);
                        state             <= EMIT;
                    end
                end

                EMIT: begin
                    if (avail_c >= AW'(W)) begin
                        if (out_free_c) begin
                            m.tdata  <= merged_c;
                            m.tkeep  <= '1;
                            m.tlast  <= 1'b0;
                            m.tvalid <= 1'b1;
                            rec_buf  <= rec_buf >> {take_n_c, 3'b000};
                            rec_rem  <= rec_rem - LW'(take_n_c);
                            res_buf  <= '0;
                            res_cnt  <= '0;
                        end
                    end else begin
                        // Tail of the record becomes residue; bytes past its length are masked off.
                        res_buf <= merged_c & lane_mask_c;
                        res_cnt <= CW'(avail_c);
                        rec_rem <= '0;
                        state   <= IDLE;
                    end
                end

                FLUSH: begin
                    if (out_free_c) begin
                        m.tdata       <= res_buf;
                        m.tkeep       <= flush_keep_c;
                        m.tlast       <= 1'b1;
                        m.tvalid      <= 1'b1;
                        res_buf       <= '0;
                        res_cnt       <= '0;
                        flush_pending <= flushIn;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_record_packer.sv
// Directed bench for stream_record_packer: packing, backpressure, ordering, clipping, reset.
module tb_stream_record_packer;
    localparam int unsigned NS = 4;
    localparam int unsigned MR = 34;
    localparam int unsigned LW = 6;

    logic clk = 1'b0;
    logic reset;
    logic [NS-1:0][MR-1:0][7:0] rec_data;
    logic [NS-1:0][LW-1:0]      rec_length;
    logic [NS-1:0]              rec_taken;
    logic                       flush_in;
    logic                       err_length;

    stream_record_packer_if #(.DATA_BUS_WIDTH_BYTES(8)) m_if ();

    stream_record_packer #(
        .DATA_BUS_WIDTH_BYTES(8),
        .MAX_RECORD_BYTES(MR),
        .NUM_SOURCES(NS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .recData(rec_data),
        .recLength(rec_length),
        .recTaken(rec_taken),
        .flushIn(flush_in),
        .errLength(err_length),
        .m(m_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] q_data[$];
    logic [7:0]  q_keep[$];
    logic        q_last[$];
    int          q_taken[$];
    logic [NS-1:0] prev_taken = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Captures accepted beats, acts as the sources (clear on recTaken) and logs take order.
    task automatic step();
        if (m_if.tvalid && m_if.tready) begin
            q_data.push_back(m_if.tdata);
            q_keep.push_back(m_if.tkeep);
            q_last.push_back(m_if.tlast);
        end
        @(posedge clk);
        #1;
        chk("taken_twice", 64'(rec_taken & prev_taken), 64'd0);
        prev_taken = rec_taken;
        for (int s = 0; s < NS; s++) begin
            if (rec_taken[s]) begin
                q_taken.push_back(s);
                rec_length[s] = '0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic flush_pulse();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
    endtask

    task automatic load_rec(input int s, input int len, input logic [7:0] base);
        for (int i = 0; i < MR; i++) rec_data[s][i] = 8'(base + 8'(i));
        rec_length[s] = LW'(len);
    endtask

    task automatic clear_logs();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        q_taken.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rec_length = '0;
        flush_in = 1'b0;
        run(2);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [63:0] d,
                            input logic [7:0] k, input logic l);
        if (idx < q_data.size()) begin
            chk({tag, "_data"}, q_data[idx], d);
            chk({tag, "_keep"}, 64'(q_keep[idx]), 64'(k));
            chk({tag, "_last"}, 64'(q_last[idx]), 64'(l));
        end else begin
            checks++;
            errors++;
            $error("FAIL %s: beat %0d missing, observed %0d beats", tag, idx, q_data.size());
        end
    endtask

    task automatic chk_taken(input string tag, input int idx, input int exp);
        if (idx < q_taken.size()) begin
            chk(tag, 64'(q_taken[idx]), 64'(exp));
        end else begin
            checks++;
            errors++;
            $error("FAIL %s: take %0d missing, observed %0d takes", tag, idx, q_taken.size());
        end
    endtask

    initial begin
        reset      = 1'b1;
        rec_data   = '0;
        rec_length = '0;
        flush_in   = 1'b0;
        m_if.tready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_tdata",  m_if.tdata, 64'd0);
        chk("rst_tkeep",  64'(m_if.tkeep), 64'd0);
        chk("rst_tlast",  64'(m_if.tlast), 64'd0);
        chk("rst_taken",  64'(rec_taken), 64'd0);
        chk("rst_err",    64'(err_length), 64'd0);

        // 1) 20-byte record, latency, residue flush
        m_if.tready = 1'b1;
        load_rec(0, 20, 8'h00);
        step();
        chk("t1_taken_n1",  64'(rec_taken), 64'h1);
        chk("t1_tvalid_n1", 64'(m_if.tvalid), 64'd0);
        step();
        chk("t1_tvalid_n2", 64'(m_if.tvalid), 64'd1);
        run(6);
        chk("t1_nbeats_pre", 64'(q_data.size()), 64'd2);
        flush_pulse();
        run(6);
        chk("t1_nbeats", 64'(q_data.size()), 64'd3);
        chk_beat("t1_b0", 0, 64'h0706050403020100, 8'hFF, 1'b0);
        chk_beat("t1_b1", 1, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0);
        chk_beat("t1_b2", 2, 64'h0000000013121110, 8'h0F, 1'b1);

        // 2) two records merged across a beat boundary
        do_reset();
        m_if.tready = 1'b1;
        load_rec(0, 5, 8'hA0);
        load_rec(1, 11, 8'hB0);
        run(10);
        chk("t2_nbeats", 64'(q_data.size()), 64'd2);
        chk_beat("t2_b0", 0, 64'hB2B1B0A4A3A2A1A0, 8'hFF, 1'b0);
        chk_beat("t2_b1", 1, 64'hBAB9B8B7B6B5B4B3, 8'hFF, 1'b0);
        chk("t2_ntaken", 64'(q_taken.size()), 64'd2);
        chk_taken("t2_take0", 0, 0);
        chk_taken("t2_take1", 1, 1);
        flush_pulse();
        run(6);
        chk("t2_empty_flush", 64'(q_data.size()), 64'd2);
        load_rec(2, 3, 8'hF0);
        run(8);
        chk("t2_no_stale_flush", 64'(q_data.size()), 64'd2);
        chk_taken("t2_take2", 2, 2);

        // 3) backpressure on the first beat
        do_reset();
        m_if.tready = 1'b0;
        load_rec(0, 20, 8'h00);
        run(2);
        chk("t3_tvalid", 64'(m_if.tvalid), 64'd1);
        chk("t3_first", m_if.tdata, 64'h0706050403020100);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_valid", 64'(m_if.tvalid), 64'd1);
            chk("t3_hold_data", m_if.tdata, 64'h0706050403020100);
            chk("t3_hold_keep", 64'(m_if.tkeep), 64'hFF);
        end
        m_if.tready = 1'b1;
        run(8);
        flush_pulse();
        run(6);
        chk("t3_nbeats", 64'(q_data.size()), 64'd3);
        chk_beat("t3_b0", 0, 64'h0706050403020100, 8'hFF, 1'b0);
        chk_beat("t3_b1", 1, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0);
        chk_beat("t3_b2", 2, 64'h0000000013121110, 8'h0F, 1'b1);

        // 4) strict ring order: src1 waits for empty src0
        do_reset();
        m_if.tready = 1'b1;
        load_rec(1, 8, 8'hD0);
        run(6);
        chk("t4_wait_taken", 64'(q_taken.size()), 64'd0);
        chk("t4_wait_beats", 64'(q_data.size()), 64'd0);
        load_rec(0, 3, 8'hC0);
        run(10);
        chk("t4_ntaken", 64'(q_taken.size()), 64'd2);
        chk_taken("t4_take0", 0, 0);
        chk_taken("t4_take1", 1, 1);
        flush_pulse();
        run(6);
        chk("t4_nbeats", 64'(q_data.size()), 64'd2);
        chk_beat("t4_b0", 0, 64'hD4D3D2D1D0C2C1C0, 8'hFF, 1'b0);
        chk_beat("t4_b1", 1, 64'h0000000000D7D6D5, 8'h07, 1'b1);

        // 5) over-length record is clipped, error is sticky
        do_reset();
        m_if.tready = 1'b1;
        load_rec(0, 40, 8'h40);
        step();
        chk("t5_err_set", 64'(err_length), 64'd1);
        run(12);
        flush_pulse();
        run(6);
        chk("t5_nbeats", 64'(q_data.size()), 64'd5);
        chk_beat("t5_b0", 0, 64'h4746454443424140, 8'hFF, 1'b0);
        chk_beat("t5_b3", 3, 64'h5F5E5D5C5B5A5958, 8'hFF, 1'b0);
        chk_beat("t5_b4", 4, 64'h0000000000006160, 8'h03, 1'b1);
        chk("t5_err_sticky", 64'(err_length), 64'd1);
        do_reset();
        chk("t5_err_cleared", 64'(err_length), 64'd0);

        // 6) reset during EMIT of a full-size record
        m_if.tready = 1'b0;
        load_rec(0, 34, 8'h40);
        run(4);
        chk("t6_stalled", 64'(m_if.tvalid), 64'd1);
        reset = 1'b1;
        rec_length = '0;
        step();
        chk("t6_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("t6_rst_taken",  64'(rec_taken), 64'd0);
        reset = 1'b0;
        m_if.tready = 1'b1;
        clear_logs();
        run(3);
        chk("t6_quiet", 64'(q_data.size()), 64'd0);
        load_rec(0, 3, 8'hE0);
        run(6);
        flush_pulse();
        run(6);
        chk("t6_ntaken", 64'(q_taken.size()), 64'd1);
        chk_taken("t6_take0", 0, 0);
        chk("t6_nbeats", 64'(q_data.size()), 64'd1);
        chk_beat("t6_b0", 0, 64'h0000000000E2E1E0, 8'h07, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
